// File: rtl/truth_sweep_checker.sv
// rtl/truth_sweep_checker.sv - exhaustive truth-table sweep checker
// Walks every input vector through a combinational DUT and compares each response with a golden table.
module truth_sweep_checker #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 2,
  parameter logic [N_OUT*(2**N_IN)-1:0] EXPECTED = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop_on_fail,
  input  logic [N_OUT-1:0]  dut_out,
  output logic [N_IN-1:0]   vec,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic              fail_valid,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic [N_OUT-1:0]  first_fail_got
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [N_IN-1:0]  VEC_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_stop;
  logic [N_IN-1:0]   r_vec;
  logic [N_IN:0]     r_err_count;
  logic              r_fail_valid;
  logic [N_IN-1:0]   r_ff_vec;
  logic [N_OUT-1:0]  r_ff_got;

  int unsigned       w_base;
  logic [N_OUT-1:0]  w_exp;
  logic              w_accept;
  logic              w_mismatch;
  logic              w_finish;

  assign w_base     = 32'(r_vec) * 32'(N_OUT);
  assign w_exp      = N_OUT'(EXPECTED >> w_base);
  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_mismatch = (r_state == S_SAMPLE) && (dut_out != w_exp);
  // The sweep ends on the last vector, or early on a mismatch when stop-on-fail was latched.
  assign w_finish   = (r_vec == VEC_LAST) || (w_mismatch && r_stop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start)          w_next = S_SETTLE;
      S_SETTLE:       if (r_cnt == '0)    w_next = S_SAMPLE;
      S_SAMPLE:       w_next = w_finish ? S_DONE : S_SETTLE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy           = (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    done           = (r_state == S_DONE);
    pass           = (r_state == S_DONE) && (r_err_count == '0);
    vec            = r_vec;
    err_count      = r_err_count;
    fail_valid     = r_fail_valid;
    first_fail_vec = r_ff_vec;
    first_fail_got = r_ff_got;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_stop       <= 1'b0;
      r_vec        <= '0;
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_ff_vec     <= '0;
      r_ff_got     <= '0;
    end else if (w_accept) begin
      r_cnt        <= CNT_LOAD;
      r_stop       <= stop_on_fail;
      r_vec        <= '0;
      r_err_count  <= '0;
      r_fail_valid <= 1'b0;
      r_ff_vec     <= '0;
      r_ff_got     <= '0;
    end else if (r_state == S_SETTLE) begin
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
    end else if (r_state == S_SAMPLE) begin
      if (w_mismatch) begin
        r_err_count <= r_err_count + (N_IN+1)'(1);
        if (!r_fail_valid) begin
          r_fail_valid <= 1'b1;
          r_ff_vec     <= r_vec;
          r_ff_got     <= dut_out;
        end
      end
      if (!w_finish) begin
        r_vec <= r_vec + N_IN'(1);
        r_cnt <= CNT_LOAD;
      end
    end
  end

endmodule

// File: tb/tb_truth_sweep_checker.sv
// tb/tb_truth_sweep_checker.sv - directed bench for truth_sweep_checker
module tb_truth_sweep_checker;

  localparam logic [15:0] EXP_A = 16'hA5C3;
  localparam logic [15:0] EXP_B = 16'hB1E4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;

  logic       start = 1'b0, stop_on_fail = 1'b0, fault = 1'b0;
  logic [0:0] dut_out;
  logic [3:0] vec, first_fail_vec;
  logic [4:0] err_count;
  logic [0:0] first_fail_got;
  logic       busy, done, pass, fail_valid;

  logic       start_b = 1'b0, stop_b = 1'b0, fault_b = 1'b0;
  logic [1:0] dut_out_b, ffg_b;
  logic [2:0] vec_b, ffv_b;
  logic [3:0] err_b;
  logic       busy_b, done_b, pass_b, fv_b;

  assign dut_out   = EXP_A[vec] ^ (fault && (vec == 4'd9 || vec == 4'd12));
  assign dut_out_b = EXP_B[int'(vec_b)*2 +: 2] ^ {2{fault_b && (vec_b == 3'd3)}};

  truth_sweep_checker #(.N_IN(4), .N_OUT(1), .SETTLE(2), .EXPECTED(EXP_A)) u_a (
    .clk(clk), .rst(rst), .start(start), .stop_on_fail(stop_on_fail), .dut_out(dut_out),
    .vec(vec), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .first_fail_vec(first_fail_vec), .first_fail_got(first_fail_got)
  );

  truth_sweep_checker #(.N_IN(3), .N_OUT(2), .SETTLE(1), .EXPECTED(EXP_B)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .stop_on_fail(stop_b), .dut_out(dut_out_b),
    .vec(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .fail_valid(fv_b), .first_fail_vec(ffv_b), .first_fail_got(ffg_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first cycle after the start edge.
  task automatic start_a(input logic sof);
    stop_on_fail = sof;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns the 1-based cycle index (start edge = 0) at which done is seen.
  task automatic run_to_done_a(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    start_b = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b%b exp=000", busy, done, pass); end
    checks++; if (vec !== 4'd0 || err_count !== 5'd0) begin failures++; $display("FAIL rst_vec_err got=%0d/%0d exp=0/0", vec, err_count); end
    checks++; if (fail_valid !== 1'b0 || first_fail_vec !== 4'd0 || first_fail_got !== 1'b0) begin failures++; $display("FAIL rst_ff got=%b/%0d/%b exp=0/0/0", fail_valid, first_fail_vec, first_fail_got); end
    checks++; if (busy_b !== 1'b0 || done_b !== 1'b0 || vec_b !== 3'd0 || err_b !== 4'd0) begin failures++; $display("FAIL rst_b got=%b%b/%0d/%0d exp=00/0/0", busy_b, done_b, vec_b, err_b); end
    start = 1'b0;
    start_b = 1'b0;
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_idle got=%b%b exp=00", busy, done); end
  endtask

  task automatic test_pass_sweep();
    fault = 1'b0;
    start_a(1'b0);
    for (int c = 1; c <= 48; c++) begin
      checks++; if (vec !== 4'((c-1)/3)) begin failures++; $display("FAIL ps_vec c=%0d got=%0d exp=%0d", c, vec, (c-1)/3); end
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL ps_busy c=%0d got=%b%b exp=10", c, busy, done); end
      tick();
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ps_done got=%b%b exp=10", done, busy); end
    checks++; if (pass !== 1'b1 || err_count !== 5'd0 || fail_valid !== 1'b0) begin failures++; $display("FAIL ps_pass got=%b/%0d/%b exp=1/0/0", pass, err_count, fail_valid); end
    checks++; if (vec !== 4'd15) begin failures++; $display("FAIL ps_last_vec got=%0d exp=15", vec); end
  endtask

  task automatic test_fault_continue();
    int cyc;
    fault = 1'b1;
    start_a(1'b0);
    run_to_done_a(cyc);
    checks++; if (cyc != 49) begin failures++; $display("FAIL fc_len got=%0d exp=49", cyc); end
    checks++; if (err_count !== 5'd2) begin failures++; $display("FAIL fc_err got=%0d exp=2", err_count); end
    checks++; if (first_fail_vec !== 4'd9 || first_fail_got !== 1'b1 || fail_valid !== 1'b1) begin failures++; $display("FAIL fc_first got=%0d/%b/%b exp=9/1/1", first_fail_vec, first_fail_got, fail_valid); end
    checks++; if (pass !== 1'b0) begin failures++; $display("FAIL fc_pass got=%b exp=0", pass); end
  endtask

  task automatic test_fault_stop();
    fault = 1'b1;
    start_a(1'b1);
    repeat (29) tick();
    checks++; if (vec !== 4'd9 || busy !== 1'b1 || done !== 1'b0 || err_count !== 5'd0) begin failures++; $display("FAIL fs_sample got=%0d/%b%b/%0d exp=9/10/0", vec, busy, done, err_count); end
    tick();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL fs_done got=%b%b exp=10", done, busy); end
    checks++; if (vec !== 4'd9 || err_count !== 5'd1 || first_fail_vec !== 4'd9) begin failures++; $display("FAIL fs_state got=%0d/%0d/%0d exp=9/1/9", vec, err_count, first_fail_vec); end
    checks++; if (pass !== 1'b0 || first_fail_got !== 1'b1) begin failures++; $display("FAIL fs_pass got=%b/%b exp=0/1", pass, first_fail_got); end
  endtask

  task automatic test_rerun_from_done();
    int cyc;
    fault = 1'b0;
    start_a(1'b0);
    checks++; if (err_count !== 5'd0 || fail_valid !== 1'b0) begin failures++; $display("FAIL rr_clear got=%0d/%b exp=0/0", err_count, fail_valid); end
    checks++; if (first_fail_vec !== 4'd0 || first_fail_got !== 1'b0) begin failures++; $display("FAIL rr_ff got=%0d/%b exp=0/0", first_fail_vec, first_fail_got); end
    checks++; if (done !== 1'b0 || pass !== 1'b0 || busy !== 1'b1 || vec !== 4'd0) begin failures++; $display("FAIL rr_flags got=%b%b%b/%0d exp=001/0", done, pass, busy, vec); end
    run_to_done_a(cyc);
    checks++; if (cyc != 49 || pass !== 1'b1 || err_count !== 5'd0) begin failures++; $display("FAIL rr_done got=%0d/%b/%0d exp=49/1/0", cyc, pass, err_count); end
  endtask

  task automatic test_restart_ignored();
    int c = 1;
    bit pulsed = 0;
    bit regressed = 0;
    start_a(1'b0);
    while (done !== 1'b1 && c < 200) begin
      if (vec == 4'd5 && !pulsed) begin
        start = 1'b1;
        pulsed = 1;
      end else begin
        start = 1'b0;
      end
      if (pulsed && vec < 4'd5) regressed = 1;
      tick();
      c++;
    end
    start = 1'b0;
    checks++; if (regressed || c != 49) begin failures++; $display("FAIL ri_sweep got=%0d/%0d exp=0/49", regressed, c); end
    checks++; if (pass !== 1'b1 || vec !== 4'd15 || err_count !== 5'd0) begin failures++; $display("FAIL ri_pass got=%b/%0d/%0d exp=1/15/0", pass, vec, err_count); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_a(1'b0);
    run_to_done_a(cyc);
    checks++; if (cyc != 49) begin failures++; $display("FAIL bb_first got=%0d exp=49", cyc); end
    start_a(1'b0);
    checks++; if (busy !== 1'b1 || done !== 1'b0 || vec !== 4'd0) begin failures++; $display("FAIL bb_accept got=%b%b/%0d exp=10/0", busy, done, vec); end
    run_to_done_a(cyc);
    checks++; if (cyc != 49 || pass !== 1'b1) begin failures++; $display("FAIL bb_second got=%0d/%b exp=49/1", cyc, pass); end
  endtask

  task automatic test_async_reset();
    int cyc;
    fault = 1'b0;
    start_a(1'b0);
    repeat (21) tick();
    checks++; if (vec !== 4'd7 || busy !== 1'b1) begin failures++; $display("FAIL ar_pre got=%0d/%b exp=7/1", vec, busy); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (vec !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin failures++; $display("FAIL ar_async got=%0d/%b%b%b exp=0/000", vec, busy, done, pass); end
    checks++; if (err_count !== 5'd0 || fail_valid !== 1'b0 || first_fail_vec !== 4'd0) begin failures++; $display("FAIL ar_regs got=%0d/%b/%0d exp=0/0/0", err_count, fail_valid, first_fail_vec); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || vec !== 4'd0) begin failures++; $display("FAIL ar_idle got=%b%b/%0d exp=00/0", busy, done, vec); end
    start_a(1'b0);
    run_to_done_a(cyc);
    checks++; if (cyc != 49 || pass !== 1'b1 || err_count !== 5'd0) begin failures++; $display("FAIL ar_sweep got=%0d/%b/%0d exp=49/1/0", cyc, pass, err_count); end
  endtask

  task automatic test_small_config();
    fault_b = 1'b0;
    stop_b = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      checks++; if (vec_b !== 3'((c-1)/2) || done_b !== 1'b0) begin failures++; $display("FAIL sm_vec c=%0d got=%0d/%b exp=%0d/0", c, vec_b, done_b, (c-1)/2); end
      tick();
    end
    checks++; if (done_b !== 1'b1 || pass_b !== 1'b1 || err_b !== 4'd0 || busy_b !== 1'b0) begin failures++; $display("FAIL sm_done got=%b%b/%0d/%b exp=11/0/0", done_b, pass_b, err_b, busy_b); end
    fault_b = 1'b1;
    stop_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (7) tick();
    checks++; if (vec_b !== 3'd3 || done_b !== 1'b0) begin failures++; $display("FAIL sm_sample got=%0d/%b exp=3/0", vec_b, done_b); end
    tick();
    checks++; if (done_b !== 1'b1 || vec_b !== 3'd3 || err_b !== 4'd1) begin failures++; $display("FAIL sm_stop got=%b/%0d/%0d exp=1/3/1", done_b, vec_b, err_b); end
    checks++; if (ffv_b !== 3'd3 || ffg_b !== 2'b00 || fv_b !== 1'b1 || pass_b !== 1'b0) begin failures++; $display("FAIL sm_first got=%0d/%b/%b/%b exp=3/00/1/0", ffv_b, ffg_b, fv_b, pass_b); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pass_sweep();
    test_fault_continue();
    test_fault_stop();
    test_rerun_from_done();
    test_restart_ignored();
    test_back_to_back();
    test_async_reset();
    test_small_config();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_sweep_checker.md
# truth_sweep_checker

Self-checking exhaustive-sweep engine for combinational blocks with N_IN inputs and N_OUT outputs. On `start` it drives every input vector 0 … 2^N_IN−1 in ascending order onto the device under test (DUT), holding each vector stable for a programmable settle time. It then samples the DUT response and compares it against a golden truth table supplied as a parameter. Mismatches are counted and the first failing vector is recorded. It sits beside any combinational module in the design and replaces hand-written, unclocked truth-table benches with a clocked, reusable checker.

## Interface
- `N_IN`, 4, number of DUT inputs (1–16)
- `N_OUT`, 1, number of DUT outputs (1–16)
- `SETTLE`, 2, cycles each vector is held before sampling (≥1)
- `EXPECTED`, all zeros, golden table of width N_OUT·2^N_IN; the entry for vector v is `EXPECTED[v*N_OUT +: N_OUT]`

Ports:
- `clk`  in  1  single system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a sweep; accepted only in IDLE or DONE
- `stop_on_fail`  in  1  sampled together with an accepted `start`; 1 = end the sweep at the first mismatch
- `dut_out`  in  N_OUT  DUT response
- `vec`  out  N_IN  vector driven to the DUT inputs (registered)
- `busy`  out  1  high while a sweep is in progress
- `done`  out  1  high in DONE; held until the next accepted `start` or reset
- `pass`  out  1  valid when `done`=1; 1 when `err_count`=0
- `err_count`  out  N_IN+1  number of mismatches in the current or last sweep
- `fail_valid`  out  1  set when at least one mismatch has been recorded
- `first_fail_vec`  out  N_IN  vector of the first mismatch
- `first_fail_got`  out  N_OUT  `dut_out` captured at the first mismatch

## Operation
- States: IDLE → SETTLE → SAMPLE → (SETTLE | DONE); DONE → SETTLE on `start`.
- Accepted `start`:
  - `vec`←0, `err_count`←0, `fail_valid`←0, `first_fail_*`←0.
  - The settle counter is loaded with SETTLE−1.
  - `stop_on_fail` is latched.
  - The state moves to SETTLE.
- `start` while `busy` is ignored.
- SETTLE:
  - The counter decrements each cycle.
  - At zero the state moves to SAMPLE.
  - `vec` is held constant throughout.
- SAMPLE: `dut_out` is compared with the table entry for `vec` on this cycle's rising edge.
  - On mismatch, `err_count` increments.
  - If `fail_valid`=0 at the time of the mismatch, `first_fail_vec`←`vec`, `first_fail_got`←`dut_out`, and `fail_valid`←1.
- Leaving SAMPLE:
  - If `vec`=2^N_IN−1, or a mismatch occurred with `stop_on_fail` latched: go to DONE with `vec` unchanged.
  - Otherwise: `vec`←`vec`+1, reload the counter, and go to SETTLE.
- `err_count` cannot overflow; its maximum value is 2^N_IN.
- Table entry indexing uses `vec` as an unsigned value. There is no wrap past 2^N_IN−1.
- `pass` = `done` & (`err_count`==0). When `done`=0, `pass` is 0.
- Reset (any state, including mid-sweep):
  - State IDLE.
  - All outputs 0: `vec`, `busy`, `done`, `pass`, `err_count`, `fail_valid`, `first_fail_vec`, `first_fail_got`.
  - Counter 0, latched `stop_on_fail` 0.
  - Takes effect immediately, without waiting for a clock edge.

## Timing
- `busy` rises in the cycle after `start` is accepted and falls in the cycle `done` rises.
- `vec`=0 appears one cycle after `start` is accepted.
- Each vector is held for SETTLE+1 cycles: SETTLE cycles in SETTLE plus 1 cycle in SAMPLE.
- A full sweep takes 2^N_IN·(SETTLE+1) cycles from the first `vec`=0 cycle to the first `done` cycle.
  - With the defaults this is 48 cycles.
- With `stop_on_fail`, `done` rises 1 cycle after the failing SAMPLE cycle.
- `err_count` and `first_fail_*` update on the SAMPLE edge and are visible in the following cycle.
- A `start` coincident with `rst`: `rst` wins.
- A `start` in the same cycle `done` first asserts: it is accepted, because the state is already DONE.
- The DUT must be purely combinational with a delay under SETTLE cycles. No DUT handshake exists.

## Test plan
- Defaults, `EXPECTED` = 16'hA5C3, DUT model matching the table:
  - `vec` steps 0..15, each value held 3 cycles.
  - `done` rises 48 cycles after the first `vec`=0 cycle.
  - `pass`=1, `err_count`=0, `fail_valid`=0.
- Same setup, DUT with output inverted at vectors 9 and 12, `stop_on_fail`=0:
  - Sweep completes.
  - `err_count`=2, `first_fail_vec`=9, `first_fail_got` equals the inverted bit at entry 9, `pass`=0.
- Same fault, `stop_on_fail`=1:
  - `done` rises 1 cycle after the vector-9 sample.
  - `vec`=9, `err_count`=1, `busy`=0.
- `start` pulsed again at `vec`=5 during a sweep: ignored. The sweep continues to 15 and completes normally.
- `rst` asserted asynchronously at `vec`=7, mid-SETTLE:
  - All outputs go to 0 immediately and the state is IDLE.
  - A later `start` yields a full passing sweep.
- Rerun from DONE after the failing sweep, with the DUT fixed:
  - Counters cleared in the cycle after `start`.
  - Final `pass`=1, `err_count`=0.
  - Also repeat with N_IN=3, N_OUT=2, SETTLE=1: 16-cycle sweep.
